// File: rtl/vx_afu_ctrl_pkg.sv
// Shared definitions for the AFU control register block: address map, CTRL
// bit positions, FSM state types and address-decode / byte-strobe helpers.
package vx_afu_ctrl_pkg;

    localparam logic [31:0] ADDR_CTRL     = 32'h00;
    localparam logic [31:0] ADDR_GIE      = 32'h04;
    localparam logic [31:0] ADDR_IER      = 32'h08;
    localparam logic [31:0] ADDR_ISR      = 32'h0C;
    localparam logic [31:0] ADDR_ARG_BASE = 32'h10;

    localparam int CTRL_START        = 0;
    localparam int CTRL_DONE         = 1;
    localparam int CTRL_IDLE         = 2;
    localparam int CTRL_READY        = 3;
    localparam int CTRL_AUTO_RESTART = 7;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {WR_IDLE = 2'd0, WR_DATA = 2'd1, WR_RESP = 2'd2} wr_state_e;
    typedef enum logic       {RD_IDLE = 1'b0, RD_DATA = 1'b1} rd_state_e;

    typedef enum logic [2:0] {REG_NONE, REG_CTRL, REG_GIE, REG_IER, REG_ISR, REG_ARG} reg_sel_e;

    typedef struct packed {
        reg_sel_e   sel;
        logic [3:0] arg_idx;
        logic       arg_hi;
    } addr_dec_t;

    // Argument i owns an 8-byte slot even when ARG_WIDTH is 32; its high word is then unmapped.
    function automatic addr_dec_t decode_addr(input logic [31:0] addr, input int num_args,
                                              input int arg_width);
        addr_dec_t   d;
        logic [31:0] a;
        logic [31:0] off;
        a         = addr & ~32'h3;
        off       = a - ADDR_ARG_BASE;
        d.sel     = REG_NONE;
        d.arg_idx = off[6:3];
        d.arg_hi  = off[2];
        if (a == ADDR_CTRL)     d.sel = REG_CTRL;
        else if (a == ADDR_GIE) d.sel = REG_GIE;
        else if (a == ADDR_IER) d.sel = REG_IER;
        else if (a == ADDR_ISR) d.sel = REG_ISR;
        else if (a >= ADDR_ARG_BASE && off[31:3] < 29'(num_args) && (!off[2] || arg_width == 64))
            d.sel = REG_ARG;
        return d;
    endfunction

    function automatic logic [31:0] apply_wstrb(input logic [31:0] old_val, input logic [31:0] new_val,
                                                input logic [3:0] strb);
        logic [31:0] r;
        for (int b = 0; b < 4; b++)
            r[b*8 +: 8] = strb[b] ? new_val[b*8 +: 8] : old_val[b*8 +: 8];
        return r;
    endfunction

endpackage

// File: rtl/vx_axil_ctrl_regs_if.sv
// AXI4-Lite control-port bundle (32-bit data) with master and slave views.
interface vx_axil_ctrl_regs_if #(
    parameter int ADDR_WIDTH = 8
);
    logic                  awvalid;
    logic                  awready;
    logic [ADDR_WIDTH-1:0] awaddr;
    logic                  wvalid;
    logic                  wready;
    logic [31:0]           wdata;
    logic [3:0]            wstrb;
    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;
    logic                  arvalid;
    logic                  arready;
    logic [ADDR_WIDTH-1:0] araddr;
    logic                  rvalid;
    logic                  rready;
    logic [31:0]           rdata;
    logic [1:0]            rresp;

    modport master (
        output awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        input  awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );

    modport slave (
        input  awvalid, awaddr, wvalid, wdata, wstrb, bready, arvalid, araddr, rready,
        output awready, wready, bvalid, bresp, arready, rvalid, rdata, rresp
    );
endinterface

// File: rtl/vx_axil_ctrl_regs.sv
// AXI4-Lite slave exposing kernel control (start/done/idle/ready), interrupt
// enable/status and a bank of kernel argument registers.
module vx_axil_ctrl_regs
    import vx_afu_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int NUM_ARGS   = 4,
    parameter int ARG_WIDTH  = 64
) (
    input  logic                          ap_clk,
    input  logic                          ap_rst_n,
    vx_axil_ctrl_regs_if.slave            s_axi_ctrl,
    output logic                          ap_start,
    input  logic                          ap_ready,
    input  logic                          ap_done,
    input  logic                          ap_idle,
    output logic [NUM_ARGS*ARG_WIDTH-1:0] args,
    output logic                          interrupt
);
    localparam int ARG_WORDS = ARG_WIDTH / 32;

    wr_state_e             r_wr_state, w_wr_next;
    rd_state_e             r_rd_state, w_rd_next;
    logic [ADDR_WIDTH-1:0] r_wr_addr;
    logic [1:0]            r_bresp, r_rresp;
    logic [31:0]           r_rdata, w_rd_data;
    logic                  r_start, r_done, r_ready, r_auto_restart, r_gie, r_interrupt;
    logic [1:0]            r_ier, r_isr, w_isr_tgl;
    addr_dec_t             w_wr_dec, w_rd_dec;
    logic                  w_aw_hs, w_w_hs, w_ar_hs, w_ctrl_wr, w_ctrl_rd;

    assign w_aw_hs  = s_axi_ctrl.awvalid & s_axi_ctrl.awready;
    assign w_w_hs   = s_axi_ctrl.wvalid & s_axi_ctrl.wready;
    assign w_ar_hs  = s_axi_ctrl.arvalid & s_axi_ctrl.arready;
    assign w_wr_dec = decode_addr(32'(r_wr_addr), NUM_ARGS, ARG_WIDTH);
    assign w_rd_dec = decode_addr(32'(s_axi_ctrl.araddr), NUM_ARGS, ARG_WIDTH);

    assign s_axi_ctrl.awready = (r_wr_state == WR_IDLE);
    assign s_axi_ctrl.wready  = (r_wr_state == WR_DATA);
    assign s_axi_ctrl.bvalid  = (r_wr_state == WR_RESP);
    assign s_axi_ctrl.bresp   = r_bresp;
    assign s_axi_ctrl.arready = (r_rd_state == RD_IDLE);
    assign s_axi_ctrl.rvalid  = (r_rd_state == RD_DATA);
    assign s_axi_ctrl.rdata   = r_rdata;
    assign s_axi_ctrl.rresp   = r_rresp;

    assign ap_start  = r_start;
    assign interrupt = r_interrupt;

    // NOTE: every output of a combinational block gets a default first, so no path can infer a latch.
    always_comb begin
        w_wr_next = r_wr_state;
        unique case (r_wr_state)
            WR_IDLE: if (s_axi_ctrl.awvalid) w_wr_next = WR_DATA;
            WR_DATA: if (s_axi_ctrl.wvalid)  w_wr_next = WR_RESP;
            WR_RESP: if (s_axi_ctrl.bready)  w_wr_next = WR_IDLE;
            default: w_wr_next = WR_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_wr_state <= WR_IDLE;
            r_wr_addr  <= '0;
            r_bresp    <= RESP_OKAY;
        end else begin
            r_wr_state <= w_wr_next;
            if (w_aw_hs) r_wr_addr <= s_axi_ctrl.awaddr;
            if (w_w_hs)  r_bresp   <= (w_wr_dec.sel == REG_NONE) ? RESP_SLVERR : RESP_OKAY;
        end
    end

    always_comb begin
        w_rd_next = r_rd_state;
        unique case (r_rd_state)
            RD_IDLE: if (s_axi_ctrl.arvalid) w_rd_next = RD_DATA;
            RD_DATA: if (s_axi_ctrl.rready)  w_rd_next = RD_IDLE;
        endcase
    end

    always_comb begin
        w_rd_data = '0;
        case (w_rd_dec.sel)
            REG_CTRL: begin
                w_rd_data[CTRL_START]        = r_start;
                w_rd_data[CTRL_DONE]         = r_done;
                w_rd_data[CTRL_IDLE]         = ap_idle;
                w_rd_data[CTRL_READY]        = r_ready;
                w_rd_data[CTRL_AUTO_RESTART] = r_auto_restart;
            end
            REG_GIE: w_rd_data[0]   = r_gie;
            REG_IER: w_rd_data[1:0] = r_ier;
            REG_ISR: w_rd_data[1:0] = r_isr;
            REG_ARG: w_rd_data = args[32*(ARG_WORDS*int'(w_rd_dec.arg_idx) + int'(w_rd_dec.arg_hi)) +: 32];
            default: ;
        endcase
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_rd_state <= RD_IDLE;
            r_rdata    <= '0;
            r_rresp    <= RESP_OKAY;
        end else begin
            r_rd_state <= w_rd_next;
            if (w_ar_hs) begin
                r_rdata <= w_rd_data;
                r_rresp <= (w_rd_dec.sel == REG_NONE) ? RESP_SLVERR : RESP_OKAY;
            end
        end
    end

    // CTRL only listens to byte 0; sticky bits clear as the CTRL read is accepted.
    assign w_ctrl_wr = w_w_hs && w_wr_dec.sel == REG_CTRL && s_axi_ctrl.wstrb[0];
    assign w_ctrl_rd = w_ar_hs && w_rd_dec.sel == REG_CTRL;
    assign w_isr_tgl = (w_w_hs && w_wr_dec.sel == REG_ISR && s_axi_ctrl.wstrb[0])
                     ? s_axi_ctrl.wdata[1:0] : 2'b00;

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_start        <= 1'b0;
            r_done         <= 1'b0;
            r_ready        <= 1'b0;
            r_auto_restart <= 1'b0;
            r_gie          <= 1'b0;
            r_ier          <= 2'b00;
            r_isr          <= 2'b00;
            r_interrupt    <= 1'b0;
        end else begin
            if (ap_ready && !r_auto_restart)                   r_start <= 1'b0;
            if (w_ctrl_wr && s_axi_ctrl.wdata[0] && ap_idle)   r_start <= 1'b1;
            if (w_ctrl_wr) r_auto_restart <= s_axi_ctrl.wdata[CTRL_AUTO_RESTART];
            r_done  <= ap_done  | (r_done  & ~w_ctrl_rd);
            r_ready <= ap_ready | (r_ready & ~w_ctrl_rd);
            if (w_w_hs && w_wr_dec.sel == REG_GIE && s_axi_ctrl.wstrb[0]) r_gie <= s_axi_ctrl.wdata[0];
            if (w_w_hs && w_wr_dec.sel == REG_IER && s_axi_ctrl.wstrb[0]) r_ier <= s_axi_ctrl.wdata[1:0];
            r_isr       <= ({ap_ready, ap_done} & r_ier) | (r_isr ^ w_isr_tgl);
            r_interrupt <= r_gie & |r_isr;
        end
    end

    for (genvar gi = 0; gi < NUM_ARGS; gi++) begin : g_arg
        logic [ARG_WORDS-1:0][31:0] r_arg;

        // NOTE: the argument bank is plain flops, not a RAM, so it is cleared by the async reset too.
        always_ff @(posedge ap_clk or negedge ap_rst_n) begin
            if (!ap_rst_n) begin
                r_arg <= '0;
            end else if (w_w_hs && w_wr_dec.sel == REG_ARG && w_wr_dec.arg_idx == 4'(gi)) begin
                for (int w = 0; w < ARG_WORDS; w++)
                    if (w_wr_dec.arg_hi == 1'(w))
                        r_arg[w] <= apply_wstrb(r_arg[w], s_axi_ctrl.wdata, s_axi_ctrl.wstrb);
            end
        end

        assign args[gi*ARG_WIDTH +: ARG_WIDTH] = r_arg;
    end

endmodule

// File: tb/tb_vx_axil_ctrl_regs.sv
// Self-checking bench: table of AXI-Lite accesses checked through per-channel
// scoreboards, then hand sequences for start/ready/done, interrupts and reset.
module tb_vx_axil_ctrl_regs;
    import vx_afu_ctrl_pkg::*;

    localparam int NUM_ARGS  = 4;
    localparam int ARG_WIDTH = 64;
    localparam int BOUND     = 50;

    logic                          ap_clk   = 1'b0;
    logic                          ap_rst_n = 1'b0;
    logic                          ap_start;
    logic                          ap_ready = 1'b0;
    logic                          ap_done  = 1'b0;
    logic                          ap_idle  = 1'b1;
    logic [NUM_ARGS*ARG_WIDTH-1:0] args;
    logic                          interrupt;

    vx_axil_ctrl_regs_if #(.ADDR_WIDTH(8)) axi ();

    vx_axil_ctrl_regs #(.ADDR_WIDTH(8), .NUM_ARGS(NUM_ARGS), .ARG_WIDTH(ARG_WIDTH)) dut (
        .ap_clk     (ap_clk),
        .ap_rst_n   (ap_rst_n),
        .s_axi_ctrl (axi),
        .ap_start   (ap_start),
        .ap_ready   (ap_ready),
        .ap_done    (ap_done),
        .ap_idle    (ap_idle),
        .args       (args),
        .interrupt  (interrupt)
    );

    always #5 ap_clk = ~ap_clk;

    typedef struct {
        logic [31:0] data;
        logic [1:0]  resp;
    } rd_exp_t;

    typedef struct {
        logic        is_read;
        logic [7:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    logic [1:0] wr_q[$];
    rd_exp_t    rd_q[$];
    vec_t       vecs[$];
    int         n_checks = 0;
    int         n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: no handshake within %0d cycles", name, BOUND);
    endtask

    task automatic axi_write(input string name, input logic [7:0] addr, input logic [31:0] data,
                             input logic [3:0] strb, input logic [1:0] exp_resp, input int b_delay);
        int n;
        logic [1:0] e;
        wr_q.push_back(exp_resp);
        @(negedge ap_clk);
        axi.awvalid = 1'b1;
        axi.awaddr  = addr;
        n = 0;
        while (!axi.awready && n < BOUND) begin @(negedge ap_clk); n++; end
        if (n == BOUND) begin timeout({name, " aw"}); axi.awvalid = 1'b0; void'(wr_q.pop_back()); return; end
        @(negedge ap_clk);
        axi.awvalid = 1'b0;
        axi.wvalid  = 1'b1;
        axi.wdata   = data;
        axi.wstrb   = strb;
        n = 0;
        while (!axi.wready && n < BOUND) begin @(negedge ap_clk); n++; end
        if (n == BOUND) begin timeout({name, " w"}); axi.wvalid = 1'b0; void'(wr_q.pop_back()); return; end
        @(negedge ap_clk);
        axi.wvalid = 1'b0;
        repeat (b_delay) @(negedge ap_clk);
        axi.bready = 1'b1;
        n = 0;
        while (!axi.bvalid && n < BOUND) begin @(negedge ap_clk); n++; end
        if (n == BOUND) begin timeout({name, " b"}); axi.bready = 1'b0; void'(wr_q.pop_back()); return; end
        e = wr_q.pop_front();
        check({name, " bresp"}, 64'(axi.bresp), 64'(e));
        @(negedge ap_clk);
        axi.bready = 1'b0;
    endtask

    task automatic axi_read(input string name, input logic [7:0] addr, input logic [31:0] exp_data,
                            input logic [1:0] exp_resp, input int r_delay);
        int n;
        rd_exp_t e;
        rd_q.push_back('{data: exp_data, resp: exp_resp});
        @(negedge ap_clk);
        axi.arvalid = 1'b1;
        axi.araddr  = addr;
        n = 0;
        while (!axi.arready && n < BOUND) begin @(negedge ap_clk); n++; end
        if (n == BOUND) begin timeout({name, " ar"}); axi.arvalid = 1'b0; void'(rd_q.pop_back()); return; end
        @(negedge ap_clk);
        axi.arvalid = 1'b0;
        repeat (r_delay) @(negedge ap_clk);
        axi.rready = 1'b1;
        n = 0;
        while (!axi.rvalid && n < BOUND) begin @(negedge ap_clk); n++; end
        if (n == BOUND) begin timeout({name, " r"}); axi.rready = 1'b0; void'(rd_q.pop_back()); return; end
        e = rd_q.pop_front();
        check({name, " rdata"}, 64'(axi.rdata), 64'(e.data));
        check({name, " rresp"}, 64'(axi.rresp), 64'(e.resp));
        @(negedge ap_clk);
        axi.rready = 1'b0;
    endtask

    task automatic pulse_ready();
        @(negedge ap_clk); ap_ready = 1'b1;
        @(negedge ap_clk); ap_ready = 1'b0;
    endtask

    function automatic vec_t mk(input logic rd, input logic [7:0] a, input logic [31:0] d,
                                input logic [3:0] s, input logic [31:0] ed, input logic [1:0] er);
        return '{is_read: rd, addr: a, data: d, strb: s, exp_data: ed, exp_resp: er};
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        axi.awvalid = 1'b0; axi.awaddr = '0; axi.wvalid = 1'b0; axi.wdata = '0; axi.wstrb = '0;
        axi.bready  = 1'b0; axi.arvalid = 1'b0; axi.araddr = '0; axi.rready = 1'b0;

        // Stimulus table: {read?, addr, wdata, wstrb, expected rdata, expected resp}
        vecs.push_back(mk(0, 8'h10, 32'hDEADBEEF, 4'hF, 32'h0,        RESP_OKAY));
        vecs.push_back(mk(0, 8'h14, 32'h12345678, 4'hF, 32'h0,        RESP_OKAY));
        vecs.push_back(mk(1, 8'h10, 32'h0,        4'h0, 32'hDEADBEEF, RESP_OKAY));
        vecs.push_back(mk(1, 8'h14, 32'h0,        4'h0, 32'h12345678, RESP_OKAY));
        vecs.push_back(mk(0, 8'h18, 32'hAABBCCDD, 4'h5, 32'h0,        RESP_OKAY));
        vecs.push_back(mk(1, 8'h18, 32'h0,        4'h0, 32'h00BB00DD, RESP_OKAY));
        vecs.push_back(mk(0, 8'h18, 32'h11223344, 4'hA, 32'h0,        RESP_OKAY));
        vecs.push_back(mk(1, 8'h18, 32'h0,        4'h0, 32'h11BB33DD, RESP_OKAY));
        vecs.push_back(mk(0, 8'h1C, 32'hCAFEF00D, 4'hF, 32'h0,        RESP_OKAY));
        vecs.push_back(mk(1, 8'h1C, 32'h0,        4'h0, 32'hCAFEF00D, RESP_OKAY));
        vecs.push_back(mk(0, 8'h04, 32'hFFFFFFFF, 4'hF, 32'h0,        RESP_OKAY));
        vecs.push_back(mk(1, 8'h04, 32'h0,        4'h0, 32'h00000001, RESP_OKAY));
        vecs.push_back(mk(0, 8'h08, 32'h00000003, 4'h0, 32'h0,        RESP_OKAY));
        vecs.push_back(mk(1, 8'h08, 32'h0,        4'h0, 32'h00000000, RESP_OKAY));
        vecs.push_back(mk(0, 8'h08, 32'h00000002, 4'h1, 32'h0,        RESP_OKAY));
        vecs.push_back(mk(1, 8'h08, 32'h0,        4'h0, 32'h00000002, RESP_OKAY));
        vecs.push_back(mk(0, 8'h08, 32'h00000000, 4'hF, 32'h0,        RESP_OKAY));
        vecs.push_back(mk(1, 8'h0C, 32'h0,        4'h0, 32'h00000000, RESP_OKAY));
        vecs.push_back(mk(0, 8'h04, 32'h00000000, 4'hF, 32'h0,        RESP_OKAY));
        vecs.push_back(mk(1, 8'h00, 32'h0,        4'h0, 32'h00000004, RESP_OKAY));
        vecs.push_back(mk(1, 8'hF0, 32'h0,        4'h0, 32'h00000000, RESP_SLVERR));
        vecs.push_back(mk(0, 8'hF0, 32'hFFFFFFFF, 4'hF, 32'h0,        RESP_SLVERR));
        vecs.push_back(mk(1, 8'h30, 32'h0,        4'h0, 32'h00000000, RESP_SLVERR));
        vecs.push_back(mk(1, 8'h2C, 32'h0,        4'h0, 32'h00000000, RESP_OKAY));
        vecs.push_back(mk(1, 8'h10, 32'h0,        4'h0, 32'hDEADBEEF, RESP_OKAY));

        // Reset state
        #1;
        check("rst awready", 64'(axi.awready), 64'd1);
        check("rst arready", 64'(axi.arready), 64'd1);
        check("rst wready",  64'(axi.wready),  64'd0);
        check("rst bvalid",  64'(axi.bvalid),  64'd0);
        check("rst rvalid",  64'(axi.rvalid),  64'd0);
        check("rst ap_start", 64'(ap_start),   64'd0);
        check("rst interrupt", 64'(interrupt), 64'd0);
        check("rst args nonzero", 64'(|args),  64'd0);
        repeat (2) @(negedge ap_clk);
        ap_rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            if (vecs[i].is_read)
                axi_read($sformatf("vec%0d rd 0x%0h", i, vecs[i].addr), vecs[i].addr,
                         vecs[i].exp_data, vecs[i].exp_resp, i % 3);
            else
                axi_write($sformatf("vec%0d wr 0x%0h", i, vecs[i].addr), vecs[i].addr, vecs[i].data,
                          vecs[i].strb, vecs[i].exp_resp, i % 3);
        end
        check("args0", args[63:0],    64'h12345678DEADBEEF);
        check("args1", args[127:64],  64'hCAFEF00D11BB33DD);
        check("args2", args[191:128], 64'h0);

        // Start handshake, sticky ready, busy start ignored
        axi_write("ctrl start", 8'h00, 32'h1, 4'hF, RESP_OKAY, 0);
        check("ap_start set", 64'(ap_start), 64'd1);
        ap_idle = 1'b0;
        repeat (3) @(negedge ap_clk);
        check("ap_start held", 64'(ap_start), 64'd1);
        pulse_ready();
        check("ap_start cleared by ready", 64'(ap_start), 64'd0);
        axi_read("ctrl ready sticky", 8'h00, 32'h08, RESP_OKAY, 0);
        ap_idle = 1'b1;
        axi_read("ctrl after clear", 8'h00, 32'h04, RESP_OKAY, 0);
        ap_idle = 1'b0;
        axi_write("ctrl start busy", 8'h00, 32'h1, 4'hF, RESP_OKAY, 0);
        check("ap_start busy ignored", 64'(ap_start), 64'd0);
        ap_idle = 1'b1;

        // Done interrupt path
        axi_write("gie on", 8'h04, 32'h1, 4'hF, RESP_OKAY, 0);
        axi_write("ier done", 8'h08, 32'h1, 4'hF, RESP_OKAY, 0);
        @(negedge ap_clk); ap_done = 1'b1;
        @(negedge ap_clk); ap_done = 1'b0;
        check("irq one cycle after isr", 64'(interrupt), 64'd0);
        @(negedge ap_clk);
        check("irq asserted", 64'(interrupt), 64'd1);
        axi_read("isr done", 8'h0C, 32'h1, RESP_OKAY, 0);
        axi_read("ctrl done sticky", 8'h00, 32'h06, RESP_OKAY, 0);
        axi_read("ctrl done cleared", 8'h00, 32'h04, RESP_OKAY, 0);
        axi_write("isr toggle off", 8'h0C, 32'h1, 4'hF, RESP_OKAY, 0);
        check("irq cleared", 64'(interrupt), 64'd0);
        axi_write("isr toggle on", 8'h0C, 32'h1, 4'hF, RESP_OKAY, 0);
        check("irq after toggle on", 64'(interrupt), 64'd1);
        axi_write("isr toggle off2", 8'h0C, 32'h1, 4'hF, RESP_OKAY, 1);
        axi_write("ier off", 8'h08, 32'h0, 4'hF, RESP_OKAY, 0);
        axi_write("gie off", 8'h04, 32'h0, 4'hF, RESP_OKAY, 0);

        // Auto-restart keeps start asserted across ready pulses
        axi_write("ctrl auto start", 8'h00, 32'h81, 4'hF, RESP_OKAY, 0);
        ap_idle = 1'b0;
        pulse_ready();
        check("auto ap_start ready1", 64'(ap_start), 64'd1);
        axi_read("ctrl auto", 8'h00, 32'h89, RESP_OKAY, 2);
        pulse_ready();
        check("auto ap_start ready2", 64'(ap_start), 64'd1);
        axi_write("ctrl auto off", 8'h00, 32'h0, 4'hF, RESP_OKAY, 0);
        pulse_ready();
        check("ap_start after auto off", 64'(ap_start), 64'd0);
        ap_idle = 1'b1;
        axi_read("ctrl ready idle", 8'h00, 32'h0C, RESP_OKAY, 0);

        // Read accepted on the same edge as a write to the same register sees the old value
        fork
            axi_write("concurrent wr", 8'h20, 32'h13572468, 4'hF, RESP_OKAY, 0);
            begin @(negedge ap_clk); axi_read("concurrent rd", 8'h20, 32'h0, RESP_OKAY, 0); end
        join
        axi_read("concurrent after", 8'h20, 32'h13572468, RESP_OKAY, 0);

        // Reset during WR_DATA drops the transaction
        @(negedge ap_clk);
        axi.awvalid = 1'b1;
        axi.awaddr  = 8'h10;
        @(negedge ap_clk);
        axi.awvalid = 1'b0;
        check("wready in WR_DATA", 64'(axi.wready), 64'd1);
        #2 ap_rst_n = 1'b0;
        #1;
        check("reset wready", 64'(axi.wready), 64'd0);
        check("reset awready", 64'(axi.awready), 64'd1);
        check("reset args nonzero", 64'(|args), 64'd0);
        @(negedge ap_clk);
        ap_rst_n = 1'b1;
        axi_write("post reset wr", 8'h10, 32'h55AA55AA, 4'hF, RESP_OKAY, 0);
        check("post reset args0", args[63:0], 64'h0000000055AA55AA);
        axi_read("post reset rd hi", 8'h14, 32'h0, RESP_OKAY, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
